// File: rtl/stereo_pkg.sv
// Shared widths, sentinel values and controller state encoding for the stereo pipeline.
package stereo_pkg;

  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned SSD_W = 23;

  localparam logic [SSD_W-1:0] SSD_MAX = '1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/disparity_search_ctrl_if.sv
// Request, SSD-engine and result channels of the disparity search controller.
interface disparity_search_ctrl_if #(
  parameter int unsigned MAX_DISP = 16
) ();
  import stereo_pkg::*;

  localparam int unsigned DISP_W = $clog2(MAX_DISP);

  logic              req_valid_in;
  logic              req_ready_out;
  logic [X_W-1:0]    req_x_in;
  logic [Y_W-1:0]    req_y_in;
  logic              ssd_valid_out;
  logic [X_W-1:0]    ssd_left_x_out;
  logic [X_W-1:0]    ssd_right_x_out;
  logic [Y_W-1:0]    ssd_y_out;
  logic              ssd_valid_in;
  logic [SSD_W-1:0]  ssd_in;
  logic              res_valid_out;
  logic              res_ready_in;
  logic [DISP_W-1:0] res_disp_out;
  logic [SSD_W-1:0]  res_ssd_out;
  logic              res_err_out;

  // slave: the controller itself; master: requester, engine and result consumer
  modport slave (
    input  req_valid_in, req_x_in, req_y_in, ssd_valid_in, ssd_in, res_ready_in,
    output req_ready_out, ssd_valid_out, ssd_left_x_out, ssd_right_x_out, ssd_y_out,
           res_valid_out, res_disp_out, res_ssd_out, res_err_out
  );

  modport master (
    output req_valid_in, req_x_in, req_y_in, ssd_valid_in, ssd_in, res_ready_in,
    input  req_ready_out, ssd_valid_out, ssd_left_x_out, ssd_right_x_out, ssd_y_out,
           res_valid_out, res_disp_out, res_ssd_out, res_err_out
  );

endinterface

// File: rtl/min_tracker.sv
// Running minimum of candidate SSDs; strict-less update so ties keep the earlier disparity.
module min_tracker
  import stereo_pkg::*;
#(
  parameter int unsigned DISP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              upd,
  input  logic [SSD_W-1:0]  cand_ssd,
  input  logic [DISP_W-1:0] cand_disp,
  output logic [SSD_W-1:0]  best_ssd,
  output logic [DISP_W-1:0] best_disp
);

  logic [SSD_W-1:0]  best_ssd_q;
  logic [DISP_W-1:0] best_disp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_ssd_q  <= SSD_MAX;
      best_disp_q <= '0;
    end else if (clear) begin
      best_ssd_q  <= SSD_MAX;
      best_disp_q <= '0;
    end else if (upd && (cand_ssd < best_ssd_q)) begin
      best_ssd_q  <= cand_ssd;
      best_disp_q <= cand_disp;
    end
  end

  assign best_ssd  = best_ssd_q;
  assign best_disp = best_disp_q;

endmodule

// File: rtl/disparity_search_ctrl.sv
// Sweeps candidate disparities for one left block, one SSD request at a time, and
// returns the disparity with the smallest SSD (or an error if the engine stalls).
module disparity_search_ctrl
  import stereo_pkg::*;
#(
  parameter int unsigned MAX_DISP = 16,
  parameter int unsigned TIMEOUT  = 64
) (
  input logic                     clk_in,
  input logic                     rst_n_in,
  disparity_search_ctrl_if.slave  bus
);

  localparam int unsigned DISP_W = $clog2(MAX_DISP);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT) + 1;
  localparam logic [DISP_W-1:0] DispLast  = DISP_W'(MAX_DISP - 1);
  // Leaving on this value means the timer "reaches" TIMEOUT-1 on the transition edge.
  localparam logic [TMR_W-1:0]  TimerLast = TMR_W'(TIMEOUT - 2);

  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [DISP_W-1:0] d_q, d_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;

  logic              trk_clear, trk_upd;
  logic [SSD_W-1:0]  best_ssd;
  logic [DISP_W-1:0] best_disp;
  logic [X_W-1:0]    d_ext;
  logic              last;
  logic              issue, done;

  assign d_ext = X_W'(d_q);
  // Stop at d == x so right_x never wraps below column 0.
  assign last  = (d_q == DispLast) || (d_ext == x_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    d_d       = d_q;
    timer_d   = timer_q;
    err_d     = err_q;
    trk_clear = 1'b0;
    trk_upd   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid_in) begin
          x_d       = bus.req_x_in;
          y_d       = bus.req_y_in;
          d_d       = '0;
          err_d     = 1'b0;
          trk_clear = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.ssd_valid_in) begin
          trk_upd = 1'b1;
          if (last) begin
            state_d = StDone;
          end else begin
            d_d     = d_q + DISP_W'(1);
            state_d = StIssue;
          end
        end else if (timer_q == TimerLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.res_ready_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  min_tracker #(
    .DISP_W (DISP_W)
  ) u_min_tracker (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .clear     (trk_clear),
    .upd       (trk_upd),
    .cand_ssd  (bus.ssd_in),
    .cand_disp (d_q),
    .best_ssd  (best_ssd),
    .best_disp (best_disp)
  );

  assign issue = (state_q == StIssue);
  assign done  = (state_q == StDone);

  assign bus.req_ready_out   = (state_q == StIdle);
  assign bus.ssd_valid_out   = issue;
  assign bus.ssd_left_x_out  = issue ? x_q : '0;
  assign bus.ssd_right_x_out = issue ? (x_q - d_ext) : '0;
  assign bus.ssd_y_out       = issue ? y_q : '0;
  assign bus.res_valid_out   = done;
  assign bus.res_disp_out    = done ? best_disp : '0;
  assign bus.res_ssd_out     = done ? best_ssd : '0;
  assign bus.res_err_out     = done & err_q;

endmodule

// File: tb/tb_disparity_search_ctrl.sv
// Directed bench: sweep, edge clip, backpressure, timeout, async reset and stray responses.
module tb_disparity_search_ctrl;
  import stereo_pkg::*;

  localparam int unsigned MAX_DISP = 4;
  localparam int unsigned TIMEOUT  = 64;
  localparam int          ENG_LAT  = 3;

  logic clk;
  logic rst_n;

  disparity_search_ctrl_if #(.MAX_DISP(MAX_DISP)) bus ();

  disparity_search_ctrl #(
    .MAX_DISP (MAX_DISP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Engine model plus stray-pulse injector
  logic             eng_valid = 1'b0;
  logic [SSD_W-1:0] eng_ssd   = '0;
  logic             stray_valid = 1'b0;
  logic [SSD_W-1:0] stray_ssd   = '0;
  logic [SSD_W-1:0] eng_tab [0:7];
  bit               eng_drop [0:7];
  int               eng_idx = 0;
  int               eng_cur = 0;
  int               eng_cnt = 0;
  int               resp_cyc = 0;

  int               req_rx [$];
  int               req_lx [$];
  int               req_y  [$];
  int               issue_cyc [$];

  assign bus.ssd_valid_in = eng_valid | stray_valid;
  assign bus.ssd_in       = stray_valid ? stray_ssd : eng_ssd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    eng_valid = 1'b0;
    if (eng_cnt != 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_valid = 1'b1;
        eng_ssd   = eng_tab[eng_cur];
        resp_cyc  = cyc;
      end
    end
    if (bus.ssd_valid_out) begin
      req_rx.push_back(int'(bus.ssd_right_x_out));
      req_lx.push_back(int'(bus.ssd_left_x_out));
      req_y.push_back(int'(bus.ssd_y_out));
      issue_cyc.push_back(cyc);
      eng_cur = eng_idx;
      eng_idx++;
      eng_cnt = eng_drop[eng_cur & 7] ? 0 : ENG_LAT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    req_rx.delete();
    req_lx.delete();
    req_y.delete();
    issue_cyc.delete();
    eng_idx = 0;
    for (int i = 0; i < 8; i++) eng_drop[i] = 1'b0;
  endtask

  task automatic start_req(input int x, input int y);
    bus.req_x_in     = X_W'(x);
    bus.req_y_in     = Y_W'(y);
    bus.req_valid_in = 1'b1;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int budget);
    int n = 0;
    while (!bus.res_valid_out && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.res_valid_out, 1);
  endtask

  task automatic accept();
    bus.res_ready_in = 1'b1;
    @(negedge clk);
    bus.res_ready_in = 1'b0;
  endtask

  initial begin
    bit stable;
    int res_cyc;

    rst_n            = 1'b0;
    bus.req_valid_in = 1'b0;
    bus.req_x_in     = '0;
    bus.req_y_in     = '0;
    bus.res_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      eng_tab[i]  = '0;
      eng_drop[i] = 1'b0;
    end
    repeat (2) @(negedge clk);

    check("reset req_ready", bus.req_ready_out, 1);
    check("reset ssd_valid", bus.ssd_valid_out, 0);
    check("reset res_valid", bus.res_valid_out, 0);
    check("reset res_ssd", bus.res_ssd_out, 0);
    check("reset res_err", bus.res_err_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sweep: SSDs 900,400,700,400 -> d=1 wins, tie at d=3 ignored
    clear_log();
    eng_tab[0] = 900; eng_tab[1] = 400; eng_tab[2] = 700; eng_tab[3] = 400;
    start_req(10, 5);
    wait_res("basic res_valid", 100);
    res_cyc = cyc;
    check("basic req count", req_rx.size(), 4);
    check("basic right_x0", req_rx[0], 10);
    check("basic right_x1", req_rx[1], 9);
    check("basic right_x2", req_rx[2], 8);
    check("basic right_x3", req_rx[3], 7);
    check("basic left_x3", req_lx[3], 10);
    check("basic y0", req_y[0], 5);
    check("basic res latency", res_cyc - resp_cyc, 1);
    check("basic disp", bus.res_disp_out, 1);
    check("basic ssd", bus.res_ssd_out, 400);
    check("basic err", bus.res_err_out, 0);

    // Backpressure: result held stable for 10 cycles
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.res_valid_out || bus.res_disp_out != 1 || bus.res_ssd_out != 400 ||
          bus.req_ready_out) stable = 1'b0;
    end
    check("backpressure stable", stable, 1);
    bus.res_ready_in = 1'b1;
    check("handshake req_ready low", bus.req_ready_out, 0);
    @(negedge clk);
    bus.res_ready_in = 1'b0;
    check("after handshake req_ready", bus.req_ready_out, 1);
    check("after handshake res_valid", bus.res_valid_out, 0);

    // Edge clip at x=2: only d=0..2, right_x never wraps
    clear_log();
    eng_tab[0] = 50; eng_tab[1] = 30; eng_tab[2] = 60; eng_tab[3] = 10;
    start_req(2, 7);
    wait_res("clip res_valid", 100);
    check("clip req count", req_rx.size(), 3);
    check("clip right_x2", req_rx[2], 0);
    check("clip disp", bus.res_disp_out, 1);
    check("clip ssd", bus.res_ssd_out, 30);
    accept();

    // Timeout on second candidate
    clear_log();
    eng_tab[0] = 123; eng_drop[1] = 1'b1;
    start_req(10, 1);
    wait_res("timeout res_valid", 200);
    res_cyc = cyc;
    check("timeout req count", req_rx.size(), 2);
    check("timeout delay", res_cyc - issue_cyc[1], 64);
    check("timeout err", bus.res_err_out, 1);
    check("timeout ssd", bus.res_ssd_out, 123);
    check("timeout disp", bus.res_disp_out, 0);
    accept();

    // Async reset mid-WAIT with stray responses during and after reset
    clear_log();
    eng_drop[0] = 1'b1;
    start_req(10, 2);
    check("reset-test issue", bus.ssd_valid_out, 1);
    repeat (2) @(negedge clk);
    rst_n       = 1'b0;
    stray_valid = 1'b1;
    stray_ssd   = 5;
    #1;
    check("async reset req_ready", bus.req_ready_out, 1);
    check("async reset ssd_valid", bus.ssd_valid_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.res_valid_out || bus.ssd_valid_out || !bus.req_ready_out) stable = 1'b0;
    end
    check("post-reset idle", stable, 1);

    // Stray ssd=0 in IDLE and in the ISSUE cycle must not pollute the minimum
    clear_log();
    eng_tab[0] = 900; eng_tab[1] = 400; eng_tab[2] = 700; eng_tab[3] = 400;
    stray_valid = 1'b1;
    stray_ssd   = 0;
    @(negedge clk);
    stray_valid      = 1'b0;
    bus.req_x_in     = 10;
    bus.req_y_in     = 5;
    bus.req_valid_in = 1'b1;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    stray_valid      = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    wait_res("stray res_valid", 100);
    check("stray req count", req_rx.size(), 4);
    check("stray disp", bus.res_disp_out, 1);
    check("stray ssd", bus.res_ssd_out, 400);
    check("stray err", bus.res_err_out, 0);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
